mdu_param: RTL and testbench
============================

Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core.
- Successor of the fixed 32-bit mult/div block driven by start, busy_E and mult_div_sel_E.
- Adds configurable width and per-class latency, MADD/MADDU/MSUB/MSUBU accumulate ops, defined divide-by-zero and overflow results, and a flush input.
- Owns HI/LO; the hazard controller stalls on start|busy when a HI/LO-touching instruction is in D.

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (must be >=1).
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; clears all state.
start  input  1  E-stage op valid this cycle (from controller).
op  input  4  operation select (encodings in package).
a  input  WIDTH  forwarded rs value (E stage).
b  input  WIDTH  forwarded rt value (E stage).
flush  input  1  abort in-flight op; HI/LO keep their pre-op values.
busy  output  1  long op in progress.
stall_req  output  1  busy | (start & long op); controller stall term.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts it; no HI/LO update.
- States: IDLE, RUN.
- IDLE, start=1, long op (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU):
  - latch the 2*WIDTH result computed from a, b and current {hi,lo};
  - load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. At the edge where counter==1, {hi,lo} take the pending result, busy->0, go to IDLE.
- Timing: start sampled at edge t. busy is high for cycles t+1 .. t+N. New hi/lo are visible at t+N+1, the same cycle busy is low.
- MTHI/MTLO with start=1 in IDLE: hi (or lo) = a at that edge; busy stays 0.
- MFHI/MFLO: read hi/lo combinationally; no state change.
- start while busy is ignored; the controller guarantees it does not happen. Bench asserts no state change.
- start=1 with op=NOP or an undefined code: no effect.
- flush=1 in RUN: go to IDLE and busy=0 at the next edge; hi/lo unchanged.
- flush=1 together with start in IDLE: start is ignored.
- flush has priority over completion in the same cycle.
- Arithmetic:
  - MULT/MADD/MSUB are signed WIDTH x WIDTH -> 2*WIDTH; the *U forms are unsigned.
  - MADD: {hi,lo} + product, mod 2^(2*WIDTH). MSUB: {hi,lo} - product, mod 2^(2*WIDTH).
  - MADD/MSUB accumulate into {hi,lo} as sampled at start.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Boundaries:
  - b==0 (DIV or DIVU): lo = all ones, hi = a.
  - DIV with a = signed MIN and b = -1: lo = MIN, hi = 0.
  - Both run the normal DIV_CYCLES latency.
- stall_req = busy | (start & is_long_op(op) & ~flush).

Decomposition:
- Package mdu_pkg:
  - op encodings: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12;
  - is_long_op function;
  - state encoding.
- One natural sub-module: mdu_arith. Purely combinational result generator (mul/div/acc plus div-by-zero and overflow rules), which keeps mdu_param the FSM, counter and HI/LO registers.

Test Plan:
- MULT a=-3, b=7 (WIDTH 32, MULT_CYCLES 5) -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low the same cycle.
- DIVU a=100, b=7 -> after 10 busy cycles lo=14, hi=2. Repeat with DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- MTHI 1, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 -> hi=2, lo=0 after 5 cycles. MSUB a=1, b=1 from hi=lo=0 -> hi=lo=0xFFFFFFFF.
- Start MULT, assert flush on the 3rd busy cycle -> busy low next cycle; hi/lo keep pre-op values. Repeat using reset mid-op -> hi=lo=0.
- Second start during busy with op=MTHI a=0x55 -> ignored; hi equals the MULT result. stall_req=1 in the start cycle and through busy.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and op-class helpers for the
// multiply/divide unit.
package mdu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Ops that occupy the unit for several cycles and write {hi,lo} at the end.
   function automatic logic is_long_op(input logic [OP_W-1:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long_op = 1'b1;
         default:                              is_long_op = 1'b0;
      endcase
   endfunction

   // Long ops that take the divide latency.
   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      is_div_op = (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for all long MDU ops.
// Ports:
//   op    - operation select (mdu_pkg encodings)
//   a, b  - operands
//   hi,lo - current HI/LO, used as accumulator for MADD*/MSUB*
//   res_c - {new_hi, new_lo}; zero for ops that are not long ops
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [OP_W-1:0]    op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   hi,
   input  logic [WIDTH-1:0]   lo,
   output logic [2*WIDTH-1:0] res_c
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [W2-1:0]           acc, a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
   logic [WIDTH-1:0]        b_div, q_u, r_u;
   logic signed [WIDTH-1:0] q_s, r_s;
   logic                    b_zero, div_ovf;

   always_comb begin
      acc    = {hi, lo};
      // Sign-extended operands multiplied modulo 2^W2 give the signed product.
      a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
      b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
      a_zx   = {{WIDTH{1'b0}}, a};
      b_zx   = {{WIDTH{1'b0}}, b};
      prod_s = a_sx * b_sx;
      prod_u = a_zx * b_zx;

      b_zero  = (b == '0);
      div_ovf = (a == S_MIN) && (b == '1);
      // Corner cases are muxed in below; keep the divider away from them.
      b_div   = (b_zero || div_ovf) ? WIDTH'(1) : b;
      q_s     = $signed(a) / $signed(b_div);
      r_s     = $signed(a) % $signed(b_div);
      q_u     = a / b_div;
      r_u     = a % b_div;

      res_c = '0;
      case (op)
         OP_MULT:  res_c = prod_s;
         OP_MULTU: res_c = prod_u;
         OP_MADD:  res_c = acc + prod_s;
         OP_MADDU: res_c = acc + prod_u;
         OP_MSUB:  res_c = acc - prod_s;
         OP_MSUBU: res_c = acc - prod_u;
         OP_DIV: begin
            if (b_zero)       res_c = {a, {WIDTH{1'b1}}};
            else if (div_ovf) res_c = {{WIDTH{1'b0}}, S_MIN};
            else              res_c = {r_s, q_s};
         end
         OP_DIVU: begin
            if (b_zero) res_c = {a, {WIDTH{1'b1}}};
            else        res_c = {r_u, q_u};
         end
         default:  res_c = '0;
      endcase
   end

endmodule

// File: rtl/mdu_param.sv
// mdu_param: E-stage multiply/divide unit owning HI/LO.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start, op      - op valid this cycle and its encoding
//   a, b           - forwarded rs/rt values
//   flush          - abort in-flight op; HI/LO keep pre-op values
//   busy           - long op in progress
//   stall_req      - stall term for the hazard controller
//   hi, lo         - HI/LO registers
module mdu_param
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0]  pend_q, pend_d;
   logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0]  arith_res_c;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi_q),
      .lo    (lo_q),
      .res_c (arith_res_c)
   );

   // Next-state: result is captured at start and committed when the count expires.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               if (is_long_op(op)) begin
                  pend_d  = arith_res_c;
                  cnt_d   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  state_d = ST_RUN;
               end else if (op == OP_MTHI) begin
                  hi_d = a;
               end else if (op == OP_MTLO) begin
                  lo_d = a;
               end
            end
         end
         ST_RUN: begin
            // Flush wins over completion; start is ignored while running.
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               {hi_d, lo_d} = pend_q;
               state_d      = ST_IDLE;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign stall_req = busy | (start & is_long_op(op) & ~flush);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// tb_mdu_param: table-driven and hand-sequenced self-checking bench for mdu_param.
module tb_mdu_param;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy, stall_req;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic [7:0]  cycles;
   } vec_t;

   vec_t vecs [12];

   mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input logic [3:0] o, input logic [31:0] v);
      start = 1'b1; op = o; a = v;
      tick;
      start = 1'b0; op = OP_NOP;
   endtask

   // Issue one long op, count busy cycles, then compare against the scoreboard.
   task automatic run_long(input string name, input logic [3:0] o, input logic [31:0] va,
                           input logic [31:0] vb, input int exp_cyc, input logic [63:0] exp_res);
      int n;
      logic [63:0] e;
      exp_q.push_back(exp_res);
      start = 1'b1; op = o; a = va; b = vb;
      #1;
      check({name, " stall_start"}, 64'(stall_req), 64'd1);
      tick;
      start = 1'b0; op = OP_NOP;
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick;
      end
      check({name, " busy_cycles"}, 64'(n), 64'(exp_cyc));
      e = exp_q.pop_front();
      check({name, " hilo"}, {hi, lo}, e);
   endtask

   initial begin
      int n;
      logic [63:0] e;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 8'd5};
      vecs[1]  = '{OP_DIVU,  32'd100,      32'd7,        32'd0, 32'd0,        32'd2,        32'd14,       8'd10};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 8'd10};
      vecs[3]  = '{OP_DIV,   32'd5,        32'd0,        32'd0, 32'd0,        32'd5,        32'hFFFFFFFF, 8'd10};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,        32'd0,        32'h80000000, 8'd10};
      vecs[5]  = '{OP_MADDU, 32'd1,        32'd1,        32'd1, 32'hFFFFFFFF, 32'd2,        32'd0,        8'd5};
      vecs[6]  = '{OP_MSUB,  32'd1,        32'd1,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 8'd5};
      vecs[7]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000001, 8'd5};
      vecs[8]  = '{OP_DIVU,  32'd5,        32'd0,        32'd7, 32'd9,        32'd5,        32'hFFFFFFFF, 8'd10};
      vecs[9]  = '{OP_MADD,  32'hFFFFFFFE, 32'd3,        32'd0, 32'd10,       32'd0,        32'd4,        8'd5};
      vecs[10] = '{OP_MSUBU, 32'd2,        32'd3,        32'd0, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 8'd5};
      vecs[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,        32'd1,        32'hFFFFFFFD, 8'd10};

      reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
      repeat (2) tick;
      reset = 1'b0;
      check("reset busy",  64'(busy), 64'd0);
      check("reset stall", 64'(stall_req), 64'd0);
      check("reset hilo",  {hi, lo}, 64'd0);

      // Table-driven long ops, each with its own HI/LO preload.
      for (int i = 0; i < 12; i++) begin
         mt(OP_MTHI, vecs[i].pre_hi);
         check($sformatf("vec%0d mthi_busy", i), 64'(busy), 64'd0);
         mt(OP_MTLO, vecs[i].pre_lo);
         check($sformatf("vec%0d preload", i), {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
         run_long($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  int'(vecs[i].cycles), {vecs[i].exp_hi, vecs[i].exp_lo});
      end

      // flush together with start in IDLE: start ignored.
      mt(OP_MTHI, 32'h11);
      mt(OP_MTLO, 32'h22);
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4; flush = 1'b1;
      #1;
      check("idle_flush stall", 64'(stall_req), 64'd0);
      tick;
      check("idle_flush busy", 64'(busy), 64'd0);
      op = OP_MTHI; a = 32'h99;
      tick;
      start = 1'b0; flush = 1'b0; op = OP_NOP;
      check("idle_flush hilo", {hi, lo}, {32'h11, 32'h22});

      // NOP, undefined code and MFHI with start: no state change.
      start = 1'b1; op = OP_NOP; a = 32'h77;
      tick;
      op = 4'd15;
      tick;
      op = OP_MFHI;
      tick;
      start = 1'b0; op = OP_NOP;
      check("noop busy", 64'(busy), 64'd0);
      check("noop hilo", {hi, lo}, {32'h11, 32'h22});

      // Flush on the 3rd busy cycle.
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
      tick;
      start = 1'b0; op = OP_NOP;
      tick;
      tick;
      flush = 1'b1;
      #1;
      check("flush stall", 64'(stall_req), 64'd1);
      tick;
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush hilo", {hi, lo}, {32'h11, 32'h22});
      repeat (8) tick;
      check("flush hilo_late", {hi, lo}, {32'h11, 32'h22});

      // Reset mid-op.
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
      tick;
      start = 1'b0; op = OP_NOP;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("midreset busy", 64'(busy), 64'd0);
      check("midreset hilo", {hi, lo}, 64'd0);
      repeat (8) tick;
      check("midreset hilo_late", {hi, lo}, 64'd0);

      // Start (MTHI) while busy is ignored; MULT result still lands.
      exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
      start = 1'b1; op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7;
      tick;
      check("busy_start busy", 64'(busy), 64'd1);
      op = OP_MTHI; a = 32'h55;
      #1;
      check("busy_start stall", 64'(stall_req), 64'd1);
      tick;
      start = 1'b0; op = OP_NOP;
      check("busy_start hi_unchanged", 64'(hi), 64'd0);
      check("busy_start stall_busy", 64'(stall_req), 64'd1);
      n = 1;
      while (busy && n < 200) begin
         n++;
         tick;
      end
      check("busy_start busy_cycles", 64'(n), 64'd5);
      e = exp_q.pop_front();
      check("busy_start hilo", {hi, lo}, e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
